// File: rtl/debug_uart_pkg.sv
// Shared types and constants for the debug console UART transmitter.
package debug_uart_pkg;

    // Serializer states; PARITY is listed even when the parity build is off
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // 100 MHz system clock, 115200 baud
    localparam int   DEFAULT_CLK_DIV = 868;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered head-of-queue output.
// dout always presents the oldest stored entry, so a consumer can take it
// on the same edge that it pops.
module sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_n;
    logic [CNT_W-1:0]  count_n;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign rd_ptr_n = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;

    // Occupancy after this edge; simultaneous push and pop cancel out
    always_comb begin
        count_n = count;
        if (push_ok && !pop_ok) begin
            count_n = count + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_n = count - CNT_W'(1);
        end
    end

    // Control state: pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            full   <= (count_n == CNT_W'(DEPTH));
            empty  <= (count_n == '0);
        end
    end

    // Storage and head register; bypass din when the new head is being written now
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
        if (push_ok && (wr_ptr == rd_ptr_n)) begin
            dout <= din;
        end else begin
            dout <= mem[rd_ptr_n];
        end
    end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug console transmitter: buffers MMIO byte writes and sends 8N1 frames.
// Build option: define DEBUG_UART_PARITY_EN to add an even parity bit (8E1).
module debug_uart_tx
    import debug_uart_pkg::*;
#(
    parameter  int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter  int FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_cnt
);

    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_e      state;
    uart_state_e      state_n;
    logic [15:0]      baud_cnt;
    logic [15:0]      baud_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic             tx_n;
    logic             baud_done;
    logic             pop;
    logic             load;
    logic             push;
    logic             started;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] cnt_after;
`ifdef DEBUG_UART_PARITY_EN
    logic             par_bit;
`endif

    // started masks wr_ready until the first edge after reset release
    assign wr_ready  = started && !fifo_full;
    assign push      = wr_valid && wr_ready;
    assign baud_done = (baud_cnt == '0);
    assign cnt_after = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (wr_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Next-state logic: each state or bit lasts CLK_DIV cycles, baud counter reloads on every change
    always_comb begin
        state_n   = state;
        baud_n    = baud_cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        tx_n      = tx;
        pop       = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                tx_n   = UART_IDLE_LEVEL;
                baud_n = DIV_M1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    shreg_n = fifo_dout;
                    state_n = START;
                    tx_n    = ~UART_IDLE_LEVEL;
                end
            end
            START: begin
                if (baud_done) begin
                    state_n   = DATA;
                    baud_n    = DIV_M1;
                    bit_idx_n = '0;
                    tx_n      = shreg[0];
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n = DIV_M1;
                    if (bit_idx == LAST_BIT) begin
`ifdef DEBUG_UART_PARITY_EN
                        state_n = PARITY;
                        tx_n    = par_bit;
`else
                        state_n = STOP;
                        tx_n    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                        tx_n      = shreg[1];
                    end
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end
`ifdef DEBUG_UART_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_n = STOP;
                    baud_n  = DIV_M1;
                    tx_n    = UART_IDLE_LEVEL;
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_n = DIV_M1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        shreg_n = fifo_dout;
                        state_n = START;
                        tx_n    = ~UART_IDLE_LEVEL;
                    end else begin
                        state_n = IDLE;
                        tx_n    = UART_IDLE_LEVEL;
                    end
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = UART_IDLE_LEVEL;
            end
        endcase
    end

    // Control registers; tx returns idle-high immediately when reset asserts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= UART_IDLE_LEVEL;
            busy     <= 1'b0;
            started  <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_idx_n;
            tx       <= tx_n;
            busy     <= (state_n != IDLE) || (cnt_after != '0);
            started  <= 1'b1;
        end
    end

    // Data path: shift register (and parity) captured when a byte is popped
    always_ff @(posedge clk) begin
        shreg <= shreg_n;
`ifdef DEBUG_UART_PARITY_EN
        if (load) begin
            par_bit <= ^fifo_dout;
        end
`endif
    end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed testbench for debug_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
module tb_debug_uart_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef DEBUG_UART_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif
    localparam int NSLOT = HAS_PAR ? 11 : 10;
    localparam int FRAME = NSLOT * DIV;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int peak  = 0;

    logic [7:0] rx_q[$];
    logic       par_q[$];
    int         ferr = 0;

    debug_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .tx       (tx),
        .busy     (busy),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-bit sampling UART receiver
    logic [7:0] m_sh;
    logic       m_par;
    bit         m_act = 1'b0;
    int         m_cnt = 0;
    int         m_ph  = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            m_act <= 1'b0;
        end else if (!m_act) begin
            if (tx === 1'b0) begin
                m_act <= 1'b1;
                m_cnt <= 2;
                m_ph  <= 0;
            end
        end else if (m_cnt != 1) begin
            m_cnt <= m_cnt - 1;
        end else begin
            m_cnt <= DIV;
            m_ph  <= m_ph + 1;
            if (m_ph == 0) begin
                if (tx !== 1'b0) begin
                    ferr  <= ferr + 1;
                    m_act <= 1'b0;
                end
            end else if (m_ph <= 8) begin
                m_sh <= {tx, m_sh[7:1]};
            end else if (HAS_PAR && m_ph == 9) begin
                m_par <= tx;
            end else begin
                if (tx !== 1'b1) begin
                    ferr <= ferr + 1;
                end else begin
                    rx_q.push_back(m_sh);
                    par_q.push_back(m_par);
                end
                m_act <= 1'b0;
            end
        end
    end

    function automatic logic exp_bit(input logic [7:0] b, input int slot);
        if (slot == 0)                 return 1'b0;
        if (slot <= 8)                 return b[slot-1];
        if (HAS_PAR && slot == 9)      return ^b;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic acc;
        int   n;
        wr_valid = 1'b1;
        wr_data  = b;
        n = 0;
        do begin
            acc = wr_ready;
            step();
            n++;
        end while (!acc && n < 200);
        wr_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL push_accept: byte %h not accepted within %0d cycles", b, n);
        end
    endtask

    task automatic wait_idle(output int c);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        c = cyc;
        total++;
        if (busy) begin
            bad++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        rstn     = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        #2 rstn  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx !== 1'b1)       begin bad++; $display("FAIL rst_tx: got %b, required 1", tx); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        total++; if (fifo_cnt !== '0)   begin bad++; $display("FAIL rst_cnt: got %0d, required 0", fifo_cnt); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b, required 0", wr_ready); end
        rstn = 1'b1;
        step();
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rel_ready: got %b, required 1", wr_ready); end
        total++; if (tx !== 1'b1)       begin bad++; $display("FAIL rel_tx: got %b, required 1", tx); end
    endtask

    task automatic send_and_check_wave(input logic [7:0] b, input string nm);
        int base;
        int errs;
        base = rx_q.size();
        push_byte(b);
        total++; if (fifo_cnt !== CW'(1)) begin bad++; $display("FAIL %s_cnt_e0: got %0d, required 1", nm, fifo_cnt); end
        total++; if (busy !== 1'b1)       begin bad++; $display("FAIL %s_busy_e0: got %b, required 1", nm, busy); end
        total++; if (tx !== 1'b1)         begin bad++; $display("FAIL %s_tx_e0: got %b, required 1", nm, tx); end
        step();
        errs = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (tx !== exp_bit(b, k / DIV)) begin
                errs++;
                if (errs == 1)
                    $display("FAIL %s_wave: cycle E1+%0d tx=%b, required %b", nm, k, tx, exp_bit(b, k / DIV));
            end
            if (k == FRAME - 1 && busy !== 1'b1) errs++;
            step();
        end
        total++; if (errs != 0) begin bad++; $display("FAIL %s_frame: %0d wrong cycles, required 0", nm, errs); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end: got %b at E1+%0d, required 0", nm, busy, FRAME); end
        total++;
        if (rx_q.size() != base + 1 || rx_q[rx_q.size()-1] !== b) begin
            bad++;
            $display("FAIL %s_rx: got %0d new bytes, required 1 byte %h", nm, rx_q.size() - base, b);
        end
    endtask

    task automatic test_single();
        send_and_check_wave(8'h55, "single");
    endtask

    task automatic test_back_to_back();
        int base, c1, c2, f0;
        logic [7:0] exp [3];
        exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
        base = rx_q.size();
        f0   = ferr;
        peak = 0;
        push_byte(exp[0]);
        push_byte(exp[1]);
        c1 = cyc;
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL b2b_start: tx=%b at E1, required 0", tx); end
        push_byte(exp[2]);
        wait_idle(c2);
        total++; if (c2 - c1 != 3 * FRAME) begin bad++; $display("FAIL b2b_span: %0d cycles, required %0d", c2 - c1, 3 * FRAME); end
        total++; if (peak != 2) begin bad++; $display("FAIL b2b_peak: fifo_cnt peak %0d, required 2", peak); end
        total++; if (ferr != f0) begin bad++; $display("FAIL b2b_framing: %0d framing errors, required 0", ferr - f0); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rx_q.size() <= base + i || rx_q[base+i] !== exp[i]) begin
                bad++;
                $display("FAIL b2b_rx%0d: got %h, required %h", i,
                         (rx_q.size() > base + i) ? rx_q[base+i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_flow_control();
        int base, c, rel_err;
        bit saw_low, saw_reassert;
        logic [7:0] exp [6];
        for (int i = 0; i < 6; i++) exp[i] = 8'h10 + 8'(i * 3);
        base = rx_q.size();
        rel_err = 0; saw_low = 0; saw_reassert = 0;
        for (int i = 0; i < 6; i++) begin
            logic acc;
            int   n;
            wr_valid = 1'b1;
            wr_data  = exp[i];
            n = 0;
            do begin
                acc = wr_ready;
                step();
                n++;
                if (wr_ready !== (fifo_cnt != CW'(DEPTH))) rel_err++;
                if (!wr_ready) saw_low = 1;
                if (saw_low && wr_ready) saw_reassert = 1;
            end while (!acc && n < 200);
            total++; if (!acc) begin bad++; $display("FAIL flow_push%0d: not accepted", i); end
        end
        wr_valid = 1'b0;
        total++; if (rel_err != 0) begin bad++; $display("FAIL flow_ready_rel: %0d cycles wr_ready disagreed with fifo_cnt", rel_err); end
        total++; if (!saw_low)      begin bad++; $display("FAIL flow_ready_drop: wr_ready never 0, required drop at fifo_cnt=4"); end
        total++; if (!saw_reassert) begin bad++; $display("FAIL flow_ready_back: wr_ready never reasserted"); end
        wait_idle(c);
        total++; if (rx_q.size() != base + 6) begin bad++; $display("FAIL flow_count: got %0d bytes, required 6", rx_q.size() - base); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (rx_q.size() <= base + i || rx_q[base+i] !== exp[i]) begin
                bad++;
                $display("FAIL flow_rx%0d: got %h, required %h", i,
                         (rx_q.size() > base + i) ? rx_q[base+i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_full_pop();
        int base, c1, c;
        base = rx_q.size();
        push_byte(8'h60);
        push_byte(8'h61);
        c1 = cyc;
        push_byte(8'h62);
        push_byte(8'h63);
        push_byte(8'h64);
        total++; if (fifo_cnt !== CW'(DEPTH)) begin bad++; $display("FAIL full_fill: fifo_cnt=%0d, required 4", fifo_cnt); end
        wr_valid = 1'b1;
        wr_data  = 8'h65;
        while (cyc < c1 + FRAME - 1) step();
        total++; if (wr_ready !== 1'b0)       begin bad++; $display("FAIL full_ready: got %b, required 0", wr_ready); end
        step();
        total++; if (fifo_cnt !== CW'(3))     begin bad++; $display("FAIL full_pop_cnt: got %0d, required 3 (push refused)", fifo_cnt); end
        total++; if (tx !== 1'b0)             begin bad++; $display("FAIL full_pop_start: tx=%b, required 0", tx); end
        step();
        total++; if (fifo_cnt !== CW'(DEPTH)) begin bad++; $display("FAIL full_next_cnt: got %0d, required 4 (push accepted)", fifo_cnt); end
        wr_valid = 1'b0;
        wait_idle(c);
        total++; if (rx_q.size() != base + 6) begin bad++; $display("FAIL full_count: got %0d bytes, required 6", rx_q.size() - base); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (rx_q.size() <= base + i || rx_q[base+i] !== 8'h60 + 8'(i)) begin
                bad++;
                $display("FAIL full_rx%0d: got %h, required %h", i,
                         (rx_q.size() > base + i) ? rx_q[base+i] : 8'hxx, 8'h60 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, c1, c, f0;
        base = rx_q.size();
        f0   = ferr;
        push_byte(8'hA5);
        push_byte(8'h11);
        c1 = cyc;
        while (cyc < c1 + 17) step();
        total++; if (tx !== 1'b0)     begin bad++; $display("FAIL mid_bit3: tx=%b, required 0", tx); end
        total++; if (fifo_cnt !== CW'(1)) begin bad++; $display("FAIL mid_cnt: got %0d, required 1", fifo_cnt); end
        #1 rstn = 1'b0;
        #1;
        total++; if (tx !== 1'b1)       begin bad++; $display("FAIL async_tx: got %b, required 1", tx); end
        total++; if (fifo_cnt !== '0)   begin bad++; $display("FAIL async_cnt: got %0d, required 0", fifo_cnt); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL async_busy: got %b, required 0", busy); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL async_ready: got %b, required 0", wr_ready); end
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        step();
        push_byte(8'h0F);
        wait_idle(c);
        total++; if (rx_q.size() != base + 1) begin bad++; $display("FAIL mid_rx_count: got %0d bytes, required 1", rx_q.size() - base); end
        total++; if (rx_q.size() > 0 && rx_q[rx_q.size()-1] !== 8'h0F) begin bad++; $display("FAIL mid_rx: got %h, required 0f", rx_q[rx_q.size()-1]); end
        total++; if (ferr != f0) begin bad++; $display("FAIL mid_framing: %0d framing errors, required 0", ferr - f0); end
    endtask

`ifdef DEBUG_UART_PARITY_EN
    task automatic test_parity();
        send_and_check_wave(8'h07, "par07");
        total++; if (par_q[par_q.size()-1] !== 1'b1) begin bad++; $display("FAIL par07_bit: got %b, required 1", par_q[par_q.size()-1]); end
        send_and_check_wave(8'h03, "par03");
        total++; if (par_q[par_q.size()-1] !== 1'b0) begin bad++; $display("FAIL par03_bit: got %b, required 0", par_q[par_q.size()-1]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flow_control();
        test_full_pop();
        test_reset_mid();
`ifdef DEBUG_UART_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_uart_tx.md
Name: debug_uart_tx

Overview:
Debug console transmitter that sits directly downstream of the cpu core. It consumes byte writes that the core's MMIO store path issues to the console address. Bytes are buffered in a small FIFO and serialised as 8N1 UART frames on a single tx pin. It lets firmware print debug text in addition to driving the 16-bit LED output.

Parameters:
CLK_DIV, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 16, byte entries; power of two, 2..256
CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy count (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
wr_valid  in  1  core presents a byte
wr_data  in  8  byte to transmit
wr_ready  out  1  FIFO can accept a byte this cycle
tx  out  1  UART serial line, idle high
busy  out  1  a frame is in flight or the FIFO is non-empty
fifo_cnt  out  CNT_W  current FIFO occupancy

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- While rstn=0: tx=1, busy=0, fifo_cnt=0, wr_ready=0, FSM=IDLE, FIFO pointers=0, bit counters=0.
- The first edge after release: wr_ready=1.
- Asserting reset mid-frame aborts the frame. tx returns to 1 immediately, with no clock needed, and FIFO contents are discarded.
- Push: a byte is accepted on an edge where wr_valid && wr_ready.
- wr_ready = !(fifo_cnt==FIFO_DEPTH), taken from registered state only, so it has no combinational path from wr_valid.
- wr_data may change freely when wr_valid=0. Once wr_valid is high, the byte must be held until it is accepted.
- Pop: happens when FSM=IDLE and fifo_cnt!=0, or at the final edge of STOP when fifo_cnt!=0. The popped byte loads the shift register and FSM->START.
- Simultaneous push+pop: fifo_cnt is unchanged and both take effect.
- Full FIFO plus pop in the same cycle: the push is still refused, because wr_ready was 0 from the registered count.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE -> START -> DATA -> STOP -> (IDLE | START).
  - Each state lasts exactly CLK_DIV cycles, counted by a baud counter that reloads on every state or bit change.
  - DATA shifts out 8 bits, LSB first, each bit for CLK_DIV cycles. A 3-bit index counts 0..7, and the FSM moves to STOP after bit 7.
  - STOP drives tx=1 for CLK_DIV cycles.
- tx is a registered output: 0 in START, the data bit in DATA, 1 in STOP and IDLE.
- Latency: a byte pushed at edge E0 into an empty FIFO while IDLE is popped at E1. tx=0 is visible from E1, and the frame ends at E1 + 10*CLK_DIV.
- Back-to-back frames: there is no idle gap. The next start bit begins at the edge that ends STOP.
- busy = (FSM!=IDLE) || (fifo_cnt!=0), registered.

Optional Feature:
Macro DEBUG_UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even parity bit (XOR of the 8 data bits) for CLK_DIV cycles, giving 11*CLK_DIV cycles per frame. The latency end point becomes E1 + 11*CLK_DIV.
- Undefined: there is no PARITY state, frames are 8N1, and no parity logic is generated.

Decomposition:
- Shared package (debug_uart_pkg):
  - FSM state enum: IDLE, START, DATA, PARITY, STOP. PARITY is always enumerated, even when unused.
  - Constants: UART_DATA_BITS=8, UART_IDLE_LEVEL=1'b1.
  - Default CLK_DIV value.
- One sub-module: sync_fifo, a generic synchronous FIFO parameterised by width and depth.
  - Inputs: push, pop.
  - Outputs: dout, full, empty, count, all registered.
  - Asynchronous active-low reset.
- Serializer FSM, baud counter and bit counter stay in debug_uart_tx.

Test Plan:
All scenarios use CLK_DIV=4, FIFO_DEPTH=4, and a bench UART monitor that samples mid-bit.
1. Single byte 0x55 pushed while IDLE -> tx=0 from E1 for 4 cycles. Data bits 1,0,1,0,1,0,1,0 follow, then stop=1. Frame spans 40 cycles; busy falls at E1+40.
2. Push 0x41, 0x42, 0x43 back to back -> three frames with no idle gap between stop and start. The monitor decodes "ABC", and fifo_cnt reaches 2 at its peak.
3. Hold wr_valid=1 with 6 distinct bytes -> wr_ready drops when fifo_cnt=4 and reasserts after a pop. All 6 bytes are received in order with none lost or duplicated.
4. Full FIFO with a pop and wr_valid=1 in the same cycle -> the push is refused that cycle, fifo_cnt goes 4->3, and the byte is accepted the next cycle.
5. Assert rstn=0 during DATA bit 3 of 0xA5 -> tx=1 without waiting for a clock edge, fifo_cnt=0 and busy=0. After release, a new byte 0x0F transmits cleanly.
6. With DEBUG_UART_PARITY_EN defined, send 0x07 -> parity bit=1 and frame length is 44 cycles. Then send 0x03 -> parity bit=0.
